ft_tx_sched: RTL and testbench

FT_TX_SCHED -- requirements
Module: ft_tx_sched

---
 rtl/ft_tx_sched.sv | 168 ++++++++++++++++
 tb/tb_ft_tx_sched.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ft_tx_sched.sv
// ft_tx_sched: two-source burst scheduler for the FT232H synchronous FIFO
// transmit path.
//
// Purpose: arbitrates round-robin between two byte sources and moves one
// granted burst (lenN+1 bytes) into the FT232H TX FIFO. A burst that stalls
// on a full FIFO for STALL_MAX consecutive cycles is aborted. A pending
// receive (rx_pend) holds off new grants but never preempts a running burst.
//
// Ports:
//   ft_clk        in   sole clock, rising edge
//   rst           in   synchronous active-high reset
//   ft_txe_n      in   FT232H TX FIFO full flag (low = space available)
//   rx_pend       in   receive path wants the bus; blocks new grants
//   req0/req1     in   burst request per source
//   len0/len1     in   [11:0] burst length minus one, sampled at grant
//   dat0/dat1     in   [7:0] source byte
//   vld0/vld1     in   source byte valid
//   rdy0/rdy1     out  byte consumed this cycle
//   ft_wr_n       out  FT232H write strobe, active low
//   ft_dout       out  [7:0] byte toward ft_data
//   gnt           out  [1:0] one-hot grant, 00 when idle or finishing
//   done/abort    out  one-cycle end-of-burst pulses
//
// States:
//   IDLE | waiting for a request; grants when rx_pend is low
//   XFER | moving bytes of the granted burst, counting stalls
//   FIN  | one cycle: pulse done or abort, record last-served source

module ft_tx_sched #(
  parameter int STALL_MAX = 1023
) (
  input  logic        ft_clk,
  input  logic        rst,
  input  logic        ft_txe_n,
  input  logic        rx_pend,
  input  logic        req0,
  input  logic        req1,
  input  logic [11:0] len0,
  input  logic [11:0] len1,
  input  logic [7:0]  dat0,
  input  logic [7:0]  dat1,
  input  logic        vld0,
  input  logic        vld1,
  output logic        rdy0,
  output logic        rdy1,
  output logic        ft_wr_n,
  output logic [7:0]  ft_dout,
  output logic [1:0]  gnt,
  output logic        done,
  output logic        abort
);

  localparam int SW = (STALL_MAX < 2) ? 1 : $clog2(STALL_MAX + 1);
  localparam logic [SW-1:0] STALL_LIM = SW'(STALL_MAX);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    FIN  = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [1:0]    gnt_q, gnt_d;
  logic          sel_q, sel_d;     // granted source index
  logic          last_q, last_d;   // last-served source index
  logic          abort_q, abort_d; // burst ended by stall timeout
  logic [11:0]   rem_q, rem_d;
  logic [SW-1:0] stall_q, stall_d;

  logic          src_vld;
  logic          xfer;
  logic          pick;
  logic [SW-1:0] stall_inc;

  assign src_vld   = sel_q ? vld1 : vld0;
  assign stall_inc = stall_q + SW'(1);

  // Strobe and ready are held inactive while reset is asserted, even if the
  // state register still holds XFER from before the reset edge.
  assign xfer = (state_q == XFER) && !ft_txe_n && src_vld && !rst;

  always_ff @(posedge ft_clk) begin
    if (rst) begin
      state_q <= IDLE;
      gnt_q   <= 2'b00;
      sel_q   <= 1'b0;
      last_q  <= 1'b1;
      abort_q <= 1'b0;
      rem_q   <= '0;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      sel_q   <= sel_d;
      last_q  <= last_d;
      abort_q <= abort_d;
      rem_q   <= rem_d;
      stall_q <= stall_d;
    end
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    sel_d   = sel_q;
    last_d  = last_q;
    abort_d = abort_q;
    rem_d   = rem_q;
    stall_d = stall_q;
    pick    = 1'b0;

    case (state_q)
      IDLE: begin
        if (!rx_pend && (req0 || req1)) begin
          // On contention serve whichever source did not go last.
          pick    = (req0 && req1) ? ~last_q : req1;
          sel_d   = pick;
          gnt_d   = pick ? 2'b10 : 2'b01;
          rem_d   = pick ? len1 : len0;
          stall_d = '0;
          abort_d = 1'b0;
          state_d = XFER;
        end
      end

      XFER: begin
        if (!ft_txe_n) begin
          stall_d = '0;
          if (src_vld) begin
            if (rem_q == 12'd0) begin
              state_d = FIN;
              gnt_d   = 2'b00;
            end else begin
              rem_d = rem_q - 12'd1;
            end
          end
        end else begin
          // Counter stops at the limit because the burst leaves XFER then.
          stall_d = stall_inc;
          if (stall_inc == STALL_LIM) begin
            state_d = FIN;
            gnt_d   = 2'b00;
            abort_d = 1'b1;
          end
        end
      end

      FIN: begin
        last_d  = sel_q;
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
        gnt_d   = 2'b00;
      end
    endcase
  end

  assign ft_wr_n = ~xfer;
  assign rdy0    = xfer && !sel_q;
  assign rdy1    = xfer && sel_q;
  assign ft_dout = (gnt_q != 2'b00) ? (sel_q ? dat1 : dat0) : 8'h00;
  assign gnt     = gnt_q;
  assign done    = (state_q == FIN) && !abort_q;
  assign abort   = (state_q == FIN) && abort_q;

endmodule

// File: tb/tb_ft_tx_sched.sv
module tb_ft_tx_sched;

  logic        ft_clk;
  logic        rst;
  logic        ft_txe_n;
  logic        rx_pend;
  logic        req0, req1;
  logic [11:0] len0, len1;
  logic [7:0]  dat0, dat1;
  logic        vld0, vld1;

  logic        rdy0, rdy1, ft_wr_n, done, abort;
  logic [7:0]  ft_dout;
  logic [1:0]  gnt;

  logic        s_rdy0, s_rdy1, s_ft_wr_n, s_done, s_abort;
  logic [7:0]  s_ft_dout;
  logic [1:0]  s_gnt;

  int errors = 0;
  int checks = 0;

  ft_tx_sched dut (
    .ft_clk(ft_clk), .rst(rst), .ft_txe_n(ft_txe_n), .rx_pend(rx_pend),
    .req0(req0), .req1(req1), .len0(len0), .len1(len1),
    .dat0(dat0), .dat1(dat1), .vld0(vld0), .vld1(vld1),
    .rdy0(rdy0), .rdy1(rdy1), .ft_wr_n(ft_wr_n), .ft_dout(ft_dout),
    .gnt(gnt), .done(done), .abort(abort)
  );

  ft_tx_sched #(.STALL_MAX(4)) dut_s (
    .ft_clk(ft_clk), .rst(rst), .ft_txe_n(ft_txe_n), .rx_pend(rx_pend),
    .req0(req0), .req1(req1), .len0(len0), .len1(len1),
    .dat0(dat0), .dat1(dat1), .vld0(vld0), .vld1(vld1),
    .rdy0(s_rdy0), .rdy1(s_rdy1), .ft_wr_n(s_ft_wr_n), .ft_dout(s_ft_dout),
    .gnt(s_gnt), .done(s_done), .abort(s_abort)
  );

  initial ft_clk = 1'b0;
  always #5 ft_clk = ~ft_clk;

  task automatic tick();
    @(posedge ft_clk);
    #1;
  endtask

  task automatic do_reset();
    tick();
    rst = 1'b1;
    req0 = 1'b0; req1 = 1'b0; vld0 = 1'b0; vld1 = 1'b0;
    rx_pend = 1'b0; ft_txe_n = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; req0 = 1'b1; vld0 = 1'b1; ft_txe_n = 1'b0; len0 = 12'd3;
    for (int i = 0; i < 2; i++) begin
      tick();
      #2;
      checks++;
      if (gnt !== 2'b00 || ft_wr_n !== 1'b1 || rdy0 !== 1'b0 || rdy1 !== 1'b0 ||
          done !== 1'b0 || abort !== 1'b0) begin
        errors++;
        $display("FAIL reset_hold: gnt=%b wr_n=%b rdy=%b%b done=%b abort=%b, expected 00 1 00 0 0",
                 gnt, ft_wr_n, rdy1, rdy0, done, abort);
      end
    end
    tick();
    rst = 1'b0; req0 = 1'b0;
    #2;
    checks++;
    if (gnt !== 2'b00 || ft_wr_n !== 1'b1 || rdy0 !== 1'b0 || rdy1 !== 1'b0) begin
      errors++;
      $display("FAIL reset_after: gnt=%b wr_n=%b rdy=%b%b, expected 00 1 00",
               gnt, ft_wr_n, rdy1, rdy0);
    end
  endtask

  task automatic test_basic();
    do_reset();
    tick();
    req0 = 1'b1; len0 = 12'd3; vld0 = 1'b1; dat0 = 8'h11; ft_txe_n = 1'b0;
    #2;
    checks++;
    if (gnt !== 2'b00 || ft_wr_n !== 1'b1) begin
      errors++;
      $display("FAIL basic_idle: gnt=%b wr_n=%b, expected 00 1", gnt, ft_wr_n);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      req0 = 1'b0; dat0 = 8'h20 + i[7:0];
      #2;
      checks++;
      if (gnt !== 2'b01 || ft_wr_n !== 1'b0 || rdy0 !== 1'b1 || rdy1 !== 1'b0 ||
          ft_dout !== (8'h20 + i[7:0]) || done !== 1'b0) begin
        errors++;
        $display("FAIL basic_byte%0d: gnt=%b wr_n=%b rdy=%b%b dout=%h done=%b, expected 01 0 01 %h 0",
                 i, gnt, ft_wr_n, rdy1, rdy0, ft_dout, done, 8'h20 + i[7:0]);
      end
    end
    tick();
    #2;
    checks++;
    if (done !== 1'b1 || abort !== 1'b0 || gnt !== 2'b00 || ft_wr_n !== 1'b1 || ft_dout !== 8'h00) begin
      errors++;
      $display("FAIL basic_fin: done=%b abort=%b gnt=%b wr_n=%b dout=%h, expected 1 0 00 1 00",
               done, abort, gnt, ft_wr_n, ft_dout);
    end
    tick();
    #2;
    checks++;
    if (done !== 1'b0 || gnt !== 2'b00) begin
      errors++;
      $display("FAIL basic_post: done=%b gnt=%b, expected 0 00", done, gnt);
    end
  endtask

  task automatic test_round_robin();
    logic [1:0] exp_g;
    logic [7:0] exp_d;
    logic       exp_w, exp_done;
    do_reset();
    tick();
    req0 = 1'b1; req1 = 1'b1; len0 = 12'd0; len1 = 12'd0;
    vld0 = 1'b1; vld1 = 1'b1; dat0 = 8'hA0; dat1 = 8'hB1; ft_txe_n = 1'b0;
    for (int c = 0; c < 12; c++) begin
      if (c > 0) tick();
      #2;
      exp_g    = (c % 3 == 1) ? ((((c / 3) % 2) != 0) ? 2'b10 : 2'b01) : 2'b00;
      exp_w    = (c % 3 == 1) ? 1'b0 : 1'b1;
      exp_done = (c % 3 == 2);
      exp_d    = (exp_g == 2'b01) ? 8'hA0 : (exp_g == 2'b10) ? 8'hB1 : 8'h00;
      checks++;
      if (gnt !== exp_g || ft_wr_n !== exp_w || done !== exp_done || ft_dout !== exp_d ||
          rdy0 !== (exp_g == 2'b01) || rdy1 !== (exp_g == 2'b10)) begin
        errors++;
        $display("FAIL rr_cycle%0d: gnt=%b wr_n=%b done=%b dout=%h rdy=%b%b, expected %b %b %b %h",
                 c, gnt, ft_wr_n, done, ft_dout, rdy1, rdy0, exp_g, exp_w, exp_done, exp_d);
      end
    end
    req0 = 1'b0; req1 = 1'b0;
  endtask

  task automatic test_stall();
    int   writes;
    logic stl;
    writes = 0;
    do_reset();
    tick();
    req1 = 1'b1; len1 = 12'd7; vld1 = 1'b1; dat1 = 8'h5A; ft_txe_n = 1'b0;
    for (int i = 0; i < 13; i++) begin
      tick();
      req1 = 1'b0;
      stl = (i >= 3 && i < 8);
      ft_txe_n = stl;
      #2;
      checks++;
      if (gnt !== 2'b10 || ft_wr_n !== stl || rdy1 !== ~stl || rdy0 !== 1'b0 ||
          abort !== 1'b0 || done !== 1'b0) begin
        errors++;
        $display("FAIL stall_cycle%0d: gnt=%b wr_n=%b rdy=%b%b abort=%b done=%b, expected 10 %b %b0 0 0",
                 i, gnt, ft_wr_n, rdy1, rdy0, abort, done, stl, ~stl);
      end
      if (ft_wr_n === 1'b0) writes++;
    end
    tick();
    #2;
    checks++;
    if (done !== 1'b1 || abort !== 1'b0 || gnt !== 2'b00) begin
      errors++;
      $display("FAIL stall_fin: done=%b abort=%b gnt=%b, expected 1 0 00", done, abort, gnt);
    end
    checks++;
    if (writes != 8) begin
      errors++;
      $display("FAIL stall_writes: got %0d, expected 8", writes);
    end
  endtask

  task automatic test_abort();
    int   writes;
    logic stl;
    writes = 0;
    do_reset();
    tick();
    req0 = 1'b1; len0 = 12'd9; vld0 = 1'b1; dat0 = 8'h3C; ft_txe_n = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      req0 = 1'b0;
      stl = (i >= 2);
      ft_txe_n = stl;
      #2;
      checks++;
      if (s_gnt !== 2'b01 || s_ft_wr_n !== stl || s_abort !== 1'b0 || s_done !== 1'b0) begin
        errors++;
        $display("FAIL abort_cycle%0d: gnt=%b wr_n=%b abort=%b done=%b, expected 01 %b 0 0",
                 i, s_gnt, s_ft_wr_n, s_abort, s_done, stl);
      end
      if (s_ft_wr_n === 1'b0) writes++;
    end
    tick();
    #2;
    checks++;
    if (s_abort !== 1'b1 || s_done !== 1'b0 || s_gnt !== 2'b00 || s_ft_wr_n !== 1'b1) begin
      errors++;
      $display("FAIL abort_fin: abort=%b done=%b gnt=%b wr_n=%b, expected 1 0 00 1",
               s_abort, s_done, s_gnt, s_ft_wr_n);
    end
    tick();
    #2;
    checks++;
    if (s_abort !== 1'b0 || s_gnt !== 2'b00) begin
      errors++;
      $display("FAIL abort_post: abort=%b gnt=%b, expected 0 00", s_abort, s_gnt);
    end
    checks++;
    if (writes != 2) begin
      errors++;
      $display("FAIL abort_writes: got %0d, expected 2", writes);
    end
  endtask

  task automatic test_rx_pend();
    do_reset();
    tick();
    rx_pend = 1'b1; req0 = 1'b1; len0 = 12'd2; vld0 = 1'b1; dat0 = 8'h77; ft_txe_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) tick();
      #2;
      checks++;
      if (gnt !== 2'b00 || ft_wr_n !== 1'b1) begin
        errors++;
        $display("FAIL rxp_block%0d: gnt=%b wr_n=%b, expected 00 1", i, gnt, ft_wr_n);
      end
    end
    rx_pend = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      rx_pend = 1'b1; req0 = 1'b0;
      #2;
      checks++;
      if (gnt !== 2'b01 || ft_wr_n !== 1'b0 || ft_dout !== 8'h77) begin
        errors++;
        $display("FAIL rxp_byte%0d: gnt=%b wr_n=%b dout=%h, expected 01 0 77", i, gnt, ft_wr_n, ft_dout);
      end
    end
    tick();
    #2;
    checks++;
    if (done !== 1'b1 || abort !== 1'b0) begin
      errors++;
      $display("FAIL rxp_fin: done=%b abort=%b, expected 1 0", done, abort);
    end
    rx_pend = 1'b0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    // One short burst from source 0 so that last-served becomes 0.
    tick();
    req0 = 1'b1; len0 = 12'd0; vld0 = 1'b1; dat0 = 8'h42; ft_txe_n = 1'b0;
    tick();
    req0 = 1'b0;
    tick();
    tick();
    req0 = 1'b1; len0 = 12'd15;
    for (int i = 0; i < 2; i++) begin
      tick();
      req0 = 1'b0;
      #2;
      checks++;
      if (gnt !== 2'b01 || ft_wr_n !== 1'b0) begin
        errors++;
        $display("FAIL rmid_byte%0d: gnt=%b wr_n=%b, expected 01 0", i, gnt, ft_wr_n);
      end
    end
    tick();
    rst = 1'b1;
    #2;
    checks++;
    if (ft_wr_n !== 1'b1 || rdy0 !== 1'b0 || rdy1 !== 1'b0) begin
      errors++;
      $display("FAIL rmid_during: wr_n=%b rdy=%b%b, expected 1 00", ft_wr_n, rdy1, rdy0);
    end
    tick();
    rst = 1'b0; req0 = 1'b1; req1 = 1'b1; len0 = 12'd0; len1 = 12'd0; vld1 = 1'b1;
    #2;
    checks++;
    if (gnt !== 2'b00 || ft_wr_n !== 1'b1 || done !== 1'b0 || abort !== 1'b0 || rdy0 !== 1'b0) begin
      errors++;
      $display("FAIL rmid_after: gnt=%b wr_n=%b done=%b abort=%b rdy0=%b, expected 00 1 0 0 0",
               gnt, ft_wr_n, done, abort, rdy0);
    end
    tick();
    req0 = 1'b0; req1 = 1'b0;
    #2;
    checks++;
    if (gnt !== 2'b01) begin
      errors++;
      $display("FAIL rmid_regrant: gnt=%b, expected 01", gnt);
    end
    tick();
    tick();
  endtask

  initial begin
    rst = 1'b1; ft_txe_n = 1'b1; rx_pend = 1'b0;
    req0 = 1'b0; req1 = 1'b0; len0 = '0; len1 = '0;
    dat0 = '0; dat1 = '0; vld0 = 1'b0; vld1 = 1'b0;
    test_reset();
    test_basic();
    test_round_robin();
    test_stall();
    test_abort();
    test_rx_pend();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
